reset_button_debounce: RTL and testbench

Conditions a raw, bouncy, asynchronous reset push-button into a clean toggle level. It sits directly upstream of the reset pulse generator, whose external-reset input expects one level change per intended reset. The block also provides a debounced press level, a long-press pulse and a wrapping press counter for status display. Everything runs in the single system clock domain.

---
 rtl/reset_button_debounce.sv | 82 ++++++++
 tb/tb_reset_button_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reset_button_debounce.sv
// reset_button_debounce: turns a bouncy reset button into a clean toggle, press level, long-press pulse and press count
module reset_button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_CYCLES       = 2000000,
  parameter int CNT_W             = 22,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clock_xxmhz,
  input  logic       i_reset_n,
  input  logic       i_button,
  output logic       o_toggle,
  output logic       o_pressed,
  output logic       o_long_press,
  output logic [7:0] o_press_count
);
  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;
  localparam logic [CNT_W-1:0] DBC_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  logic             w_btn;
  logic             w_s;
  logic [1:0]       r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_dbc;
  logic [CNT_W-1:0] r_hold;
  logic             r_long_done;
  assign w_btn = BUTTON_ACTIVE_LOW ? ~i_button : i_button;
  assign w_s   = r_sync[1];
  // two-flop synchroniser on the polarity-normalised button, 1 = pressed
  always_ff @(posedge i_clock_xxmhz or negedge i_reset_n)
    if (!i_reset_n) r_sync <= 2'b00;
    else r_sync <= {r_sync[0], w_btn};
  // debounce FSM with registered toggle, press level, long-press pulse and count
  always_ff @(posedge i_clock_xxmhz or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_dbc         <= '0;
      r_hold        <= '0;
      r_long_done   <= 1'b0;
      o_toggle      <= 1'b0;
      o_pressed     <= 1'b0;
      o_long_press  <= 1'b0;
      o_press_count <= 8'd0;
    end else begin
      o_long_press <= 1'b0;
      case (r_state)
        IDLE:
          if (w_s) begin
            r_state <= ARMING;
            r_dbc   <= '0;
          end
        ARMING:
          if (!w_s) r_state <= IDLE;
          else if (r_dbc == DBC_LAST) begin
            r_state       <= PRESSED;
            o_toggle      <= ~o_toggle;
            o_pressed     <= 1'b1;
            o_press_count <= o_press_count + 8'd1;
            r_hold        <= '0;
          end else r_dbc <= r_dbc + ONE;
        PRESSED:
          if (!w_s) begin
            r_state <= RELEASING;
            r_dbc   <= '0;
          end else begin
            if (r_hold != HOLD_LAST) r_hold <= r_hold + ONE;
            if (r_hold == HOLD_LAST && !r_long_done) begin
              o_long_press <= 1'b1;
              r_long_done  <= 1'b1;
            end
          end
        RELEASING:
          if (w_s) r_state <= PRESSED;
          else if (r_dbc == DBC_LAST) begin
            r_state     <= IDLE;
            o_pressed   <= 1'b0;
            r_long_done <= 1'b0;
          end else r_dbc <= r_dbc + ONE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reset_button_debounce.sv
// tb_reset_button_debounce: random and directed button traffic scored against a run-length reference model
module tb_reset_button_debounce;
  localparam int D = 4;
  localparam int L = 10;
  typedef struct {int cyc; logic [10:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic tog, prs, lp;
  logic [7:0] cnt;
  ev_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic h0 = 1'b0, h1 = 1'b0, run_val = 1'b0, prev_s = 1'b0;
  logic m_p = 1'b0, m_tog = 1'b0, m_lp = 1'b0, fired = 1'b0;
  int run_len = 0;
  int hold_n = 0;
  logic [7:0] m_cnt = 8'd0;
  logic [10:0] m_v = 11'd0;
  logic [10:0] prev_v;
  logic have_prev = 1'b0;

  reset_button_debounce #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(8), .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clock_xxmhz(clk), .i_reset_n(rst_n), .i_button(btn),
    .o_toggle(tog), .o_pressed(prs), .o_long_press(lp), .o_press_count(cnt)
  );

  always #5 clk = ~clk;

  function automatic void push_if_changed(int c);
    logic [10:0] v;
    v = {m_tog, m_p, m_lp, m_cnt};
    if (v != m_v) begin
      q.push_back('{c, v});
      m_v = v;
    end
  endfunction

  function automatic void model_clear();
    h0 = 1'b0; h1 = 1'b0; run_val = 1'b0; run_len = 0; prev_s = 1'b0;
    m_p = 1'b0; m_tog = 1'b0; m_lp = 1'b0; fired = 1'b0; hold_n = 0; m_cnt = 8'd0;
  endfunction

  // debounced level flips after D+1 consecutive synchronised samples disagree with it;
  // long press fires on the L-th pressed-and-still-pressed sample after acceptance
  function automatic void model_edge(logic b);
    logic s;
    s = h1;
    h1 = h0;
    h0 = ~b;
    m_lp = 1'b0;
    if (s == run_val) run_len++;
    else begin
      run_val = s;
      run_len = 1;
    end
    if (m_p && prev_s && s) begin
      hold_n++;
      if (hold_n == L && !fired) begin
        m_lp = 1'b1;
        fired = 1'b1;
      end
    end
    if (run_val != m_p && run_len >= D + 1) begin
      m_p = run_val;
      if (m_p) begin
        m_tog = ~m_tog;
        m_cnt = m_cnt + 8'd1;
        hold_n = 0;
        fired = 1'b0;
      end
    end
    prev_s = s;
  endfunction

  task automatic step(logic b);
    btn = b;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(b);
    else begin
      h0 = 1'b0;
      h1 = 1'b0;
    end
    cyc++;
    push_if_changed(cyc);
  endtask

  task automatic hold(logic b, int n);
    repeat (n) step(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    push_if_changed(cyc + 1);
    step(btn);
    step(btn);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [10:0] v;
    ev_t e;
    v = {tog, prs, lp, cnt};
    if (!rst_n) begin
      total++;
      if (v !== 11'd0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%h want=000", cyc, v);
      end
    end
    if (have_prev && v !== prev_v) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, v);
      end else begin
        e = q.pop_front();
        if (e.v !== v || e.cyc != cyc) begin
          bad++;
          $display("FAIL output_event got=%h@%0d want=%h@%0d", v, cyc, e.v, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_change cyc=%0d got=%h want=%h@%0d", cyc, v, q[0].v, q[0].cyc);
      e = q.pop_front();
    end
    prev_v = v;
    have_prev = 1'b1;
  end

  initial begin
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 12);
    hold(1'b1, 8);
    hold(1'b0, 3);
    hold(1'b1, 8);
    hold(1'b0, 30);
    hold(1'b1, 8);
    hold(1'b0, 10);
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 8);
    hold(1'b0, 12);
    hold(1'b1, 8);
    hold(1'b0, 3);
    do_reset();
    hold(1'b0, 10);
    hold(1'b1, 8);
    hold(1'b0, 12);
    do_reset();
    hold(1'b1, 8);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      hold($urandom_range(0, 1) != 0, $urandom_range(1, 8));
    end
    hold(1'b0, 20);
    hold(1'b1, 8);
    do_reset();
    repeat (256) begin
      hold(1'b0, 6);
      hold(1'b1, 6);
    end
    hold(1'b1, 5);
    total++;
    if ({tog, cnt} !== 9'd0) begin
      bad++;
      $display("FAIL wrap_end got=toggle %b count %0d want=toggle 0 count 0", tog, cnt);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
